buffer_ctrl: RTL and testbench

Ping-pong sequencer for the TensorCore operand buffer. It accepts tiles from a producer (the loader) with a valid/ready handshake and serves them to the TensorCore consumer with a second valid/ready handshake. It drives the buffer's write/read enables and addresses directly. Each stored tile is read a configurable number of times (operand reuse) before its entry is released for refilling.

---
 rtl/buffer_ctrl_pkg.sv | 14 +
 rtl/buffer_ctrl_if.sv | 41 ++++
 rtl/buffer_reuse_cnt.sv | 58 +++++
 rtl/buffer_ctrl.sv | 102 ++++++++++
 tb/tb_buffer_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_ctrl_pkg.sv
// buffer_ctrl shared definitions
// defaults and read-side FSM encoding
package buffer_ctrl_pkg;

  localparam int DEF_DEPTH = 2;
  localparam int DEF_AW    = 1;
  localparam int DEF_RW    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } rd_state_e;

endpackage

// File: rtl/buffer_ctrl_if.sv
// buffer_ctrl handshake and buffer-port bundle
// slave = sequencer side, master = environment
interface buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 1
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_last,
    output buf_wr_en,
    output buf_wr_addr,
    output buf_rd_en,
    output buf_rd_addr
  );

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_last,
    input  buf_wr_en,
    input  buf_wr_addr,
    input  buf_rd_en,
    input  buf_rd_addr
  );

endinterface

// File: rtl/buffer_reuse_cnt.sv
// buffer_ctrl reuse counter
// counts read beats per tile, flags the last
module buffer_reuse_cnt
  import buffer_ctrl_pkg::*;
#(
  parameter int REUSE_WIDTH = DEF_RW
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   beat,
  input  logic [REUSE_WIDTH-1:0] cfg_reuse,
  output logic                   last,
  output logic                   busy
);

  rd_state_e              state_q, state_d;
  logic [REUSE_WIDTH-1:0] rcnt_q, rcnt_d;
  logic [REUSE_WIDTH-1:0] reuse_q, reuse_d;
  logic [REUSE_WIDTH-1:0] eff;

  // state, count and latched target
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      reuse_q <= REUSE_WIDTH'(1);
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      reuse_q <= reuse_d;
    end
  end

  // target selection and beat accounting
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    reuse_d = reuse_q;
    eff     = reuse_q;
    if (state_q == IDLE) begin
      eff = (cfg_reuse == '0) ?
            REUSE_WIDTH'(1) : cfg_reuse;
    end
    last = (rcnt_q == eff - REUSE_WIDTH'(1));
    busy = (state_q == SERVE);
    if (beat) begin
      if (state_q == IDLE) reuse_d = eff;
      if (last) begin
        rcnt_d  = '0;
        state_d = IDLE;
      end else begin
        rcnt_d  = rcnt_q + REUSE_WIDTH'(1);
        state_d = SERVE;
      end
    end
  end

endmodule

// File: rtl/buffer_ctrl.sv
// buffer_ctrl ping-pong operand sequencer
// entry flags, pointers and occupancy
module buffer_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int BUFFER_DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH   = DEF_AW,
  parameter int REUSE_WIDTH  = DEF_RW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [REUSE_WIDTH-1:0] cfg_reuse,
  buffer_ctrl_if.slave           bus,
  output logic [ADDR_WIDTH:0]    occupancy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(BUFFER_DEPTH - 1);

  logic                    clr;
  logic [BUFFER_DEPTH-1:0] full_q, full_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     occ_q, occ_d;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rel;
  logic                    last;
  logic                    busy;

  function automatic logic [ADDR_WIDTH-1:0]
    nxt(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign clr = rst | flush;

  buffer_reuse_cnt #(
    .REUSE_WIDTH(REUSE_WIDTH)
  ) u_reuse (
    .clk      (clk),
    .clear    (clr),
    .beat     (rd_fire),
    .cfg_reuse(cfg_reuse),
    .last     (last),
    .busy     (busy)
  );

  // handshake outputs, gated off while clearing
  always_comb begin
    bus.in_ready    = !full_q[wr_ptr_q] && !clr;
    bus.out_valid   = full_q[rd_ptr_q] && !clr;
    bus.out_last    = bus.out_valid && last;
    bus.buf_wr_en   = bus.in_valid && bus.in_ready;
    bus.buf_rd_en   = bus.out_valid;
    bus.buf_wr_addr = clr ? '0 : wr_ptr_q;
    bus.buf_rd_addr = clr ? '0 : rd_ptr_q;
    wr_fire         = bus.buf_wr_en;
    rd_fire         = bus.out_valid && bus.out_ready;
    rel             = rd_fire && last;
  end

  // next flags, pointers and occupancy
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_fire) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = nxt(wr_ptr_q);
    end
    if (rel) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = nxt(rd_ptr_q);
    end
    unique case ({wr_fire, rel})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (clr) begin
      full_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_buffer_ctrl.sv
// buffer_ctrl bench
// queue-level model plus directed scenarios
module tb_buffer_ctrl;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] cfg_reuse;
  logic [1:0] occupancy;
  bit         chk_en = 1'b0;

  int vectors = 0;
  int fails   = 0;

  buffer_ctrl_if #(.ADDR_WIDTH(1)) bus ();

  buffer_ctrl #(
    .BUFFER_DEPTH(D),
    .ADDR_WIDTH  (1),
    .REUSE_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cfg_reuse(cfg_reuse),
    .bus      (bus.slave),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: list of stored entries, next write/read slot,
  // beats served on the head tile and its latched target
  int q[$];
  int wnext = 0;
  int rnext = 0;
  int beats = 0;
  int tgt   = 1;

  always @(negedge clk) begin : model
    int n, eff;
    bit cl, e_ir, e_ov, e_last, wf, rf;
    if (chk_en) begin
      n      = q.size();
      cl     = rst || flush;
      eff    = (beats == 0) ? ((cfg_reuse == 0) ? 1 : int'(cfg_reuse)) : tgt;
      e_ir   = !cl && (n < D);
      e_ov   = !cl && (n > 0);
      e_last = e_ov && (beats == eff - 1);
      chk("in_ready", bus.in_ready, e_ir);
      chk("out_valid", bus.out_valid, e_ov);
      chk("out_last", bus.out_last, e_last);
      chk("buf_wr_en", bus.buf_wr_en, e_ir && bus.in_valid);
      chk("buf_wr_addr", bus.buf_wr_addr, cl ? 0 : wnext);
      chk("buf_rd_en", bus.buf_rd_en, e_ov);
      chk("buf_rd_addr", bus.buf_rd_addr, cl ? 0 : rnext);
      chk("occupancy", occupancy, n);
      if (cl) begin
        q.delete();
        wnext = 0;
        rnext = 0;
        beats = 0;
        tgt   = 1;
      end else begin
        wf = e_ir && bus.in_valid;
        rf = e_ov && bus.out_ready;
        if (rf) begin
          if (e_last) begin
            void'(q.pop_front());
            rnext = (rnext + 1) % D;
            beats = 0;
          end else begin
            if (beats == 0) tgt = eff;
            beats++;
          end
        end
        if (wf) begin
          q.push_back(wnext);
          wnext = (wnext + 1) % D;
        end
      end
    end
  end

  int nb, lastat, k, tot;
  int cnt [2];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cfg_reuse = 4'd1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst occupancy", occupancy, 0);
    step();
    rst = 1'b0;

    // two tiles back to back, consumer stalled
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t1 ready after rst", bus.in_ready, 1);
    chk("t1 wr_addr A", bus.buf_wr_addr, 0);
    step();
    @(negedge clk);
    chk("t1 wr_addr B", bus.buf_wr_addr, 1);
    chk("t1 wr_en B", bus.buf_wr_en, 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1 full in_ready", bus.in_ready, 0);
    chk("t1 occupancy", occupancy, 2);
    step();
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t1 drained", occupancy, 0);
    step();

    // reuse 3
    cfg_reuse = 4'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    nb = 0;
    lastat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nb++;
        chk("t2 rd_addr", bus.buf_rd_addr, 0);
        if (bus.out_last) begin
          lastat = nb;
          break;
        end
      end
    end
    step();
    bus.out_ready = 1'b0;
    chk("t2 beats", nb, 3);
    chk("t2 last on beat", lastat, 3);

    // reuse 0 means 1, pointers wrap
    flush = 1'b1;
    step();
    flush = 1'b0;
    cfg_reuse = 4'd0;
    for (int t = 0; t < 4; t++) begin
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("t3 rd_addr", bus.buf_rd_addr, t % 2);
      chk("t3 last", bus.out_last, 1);
      step();
      bus.out_ready = 1'b0;
    end

    // steady stream
    flush = 1'b1;
    step();
    flush = 1'b0;
    cfg_reuse = 4'd1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4 occupancy", occupancy, 1);
      chk("t4 wr+rd", bus.buf_wr_en && bus.buf_rd_en, 1);
      chk("t4 addr differ", bus.buf_wr_addr != bus.buf_rd_addr, 1);
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // reuse change mid-tile
    flush = 1'b1;
    step();
    flush = 1'b0;
    cfg_reuse = 4'd2;
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    nb = 0;
    k = 0;
    tot = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nb++;
        tot++;
        if (bus.out_last) begin
          cnt[k] = nb;
          nb = 0;
          k++;
        end
      end
      if (k == 2) break;
      step();
      if (tot == 1) cfg_reuse = 4'd4;
    end
    step();
    bus.out_ready = 1'b0;
    chk("t5 tile1 beats", cnt[0], 2);
    chk("t5 tile2 beats", cnt[1], 4);

    // flush mid 4-reuse tile
    flush = 1'b1;
    step();
    flush = 1'b0;
    cfg_reuse = 4'd4;
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6 occupancy pre", occupancy, 2);
    step();
    bus.out_ready = 1'b1;
    step();
    step();
    flush = 1'b1;
    bus.in_valid = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t6 out_valid", bus.out_valid, 0);
    chk("t6 occupancy", occupancy, 0);
    chk("t6 rd_addr", bus.buf_rd_addr, 0);
    chk("t6 wr_addr", bus.buf_wr_addr, 0);
    chk("t6 wr_en", bus.buf_wr_en, 1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
